// File: rtl/prog_loader.sv
// prog_loader: length-prefixed byte-stream loader that packs LO/HI byte pairs into
// 9-bit instruction words. Defining PROG_LOADER_CKSUM_EN adds a trailing XOR checksum byte.
module prog_loader #(
    parameter int ADDR_W        = 6,
    parameter int INSTR_W       = 9,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    words_loaded,
    output logic [2:0]         state_dbg
);

    localparam int       CW        = ADDR_W + 1;
    localparam int       MAX_WORDS = 2 ** ADDR_W;
    localparam logic [8:0] MAX_W9  = 9'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_LO    = 3'd2,
        S_HI    = 3'd3,
        S_CKSUM = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      len_q, len_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         cks_q, cks_d;
    logic               in_ready_q, in_ready_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [CW-1:0]      words_q, words_d;
    logic [CW-1:0]      words_inc;
    logic               xfer;

    // Handshake: a byte moves only in a cycle where in_valid and in_ready are both high;
    // in_ready is registered and never depends on in_valid, so the source may wait freely.
    assign xfer      = in_valid & in_ready_q;
    assign words_inc = words_q + 1'b1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        lo_d    = lo_q;
        cks_d   = cks_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = done_q ? 1'b0 : hold_q;
        done_d  = 1'b0;
        error_d = error_q;
        words_d = words_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    hold_d  = 1'b1;
                    error_d = 1'b0;
                    words_d = '0;
                    cks_d   = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    cks_d = in_data;
                    if ({1'b0, in_data} > MAX_W9) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        len_d   = (in_data == 8'd0) ? CW'(MAX_WORDS) : CW'(in_data);
                        state_d = S_LO;
                    end
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_d    = in_data;
                    cks_d   = cks_q ^ in_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    cks_d = cks_q ^ in_data;
                    if (in_data[7:1] != 7'd0) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_W-1:0];
                        wdata_d = INSTR_W'({in_data[0], lo_q});
                        words_d = words_inc;
                        if (words_inc == len_q) begin
`ifdef PROG_LOADER_CKSUM_EN
                            state_d = S_CKSUM;
`else
                            state_d = S_DONE;
                            done_d  = 1'b1;
`endif
                        end else begin
                            state_d = S_LO;
                        end
                    end
                end
            end
            S_CKSUM: begin
                if (xfer) begin
                    if (in_data == cks_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_LEN) || (state_d == S_LO) ||
                     (state_d == S_HI)  || (state_d == S_CKSUM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            lo_q       <= '0;
            cks_q      <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= HOLD_AT_RESET;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            lo_q       <= lo_d;
            cks_q      <= cks_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
            words_q    <= words_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: random and directed byte streams for prog_loader, checked against a
// stream-parsing reference model and a write scoreboard.
module tb_prog_loader;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 9;
    localparam int MAXW    = 64;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         in_data = 8'd0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               cpu_hold;
    logic               done;
    logic               error;
    logic [ADDR_W:0]    words_loaded;
    logic [2:0]         state_dbg;

    prog_loader #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .HOLD_AT_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_loaded(words_loaded), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [14:0] exp_q[$];
    int          done_seen = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (imem_we) begin
                if (exp_q.size() != 0)
                    check_eq("write", {17'd0, imem_addr, imem_wdata}, {17'd0, exp_q.pop_front()});
                else
                    check_eq("extra_write", {17'd0, imem_addr, imem_wdata}, 32'hDEADBEEF);
            end
            if (done) begin
                done_seen++;
`ifndef PROG_LOADER_CKSUM_EN
                check_eq("done_with_we", imem_we, 1);
`endif
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] stream_q[$];
    int         exp_consumed;
    bit         exp_done;
    bit         exp_err;
    int         exp_words;

    task automatic run_model();
        int n;
        logic [7:0] x, lo, hi;
        exp_q.delete();
        exp_done = 0; exp_err = 0; exp_words = 0;
        x = stream_q[0];
        exp_consumed = 1;
        if (stream_q[0] > MAXW) begin
            exp_err = 1;
            return;
        end
        n = (stream_q[0] == 0) ? MAXW : int'(stream_q[0]);
        for (int i = 0; i < n; i++) begin
            lo = stream_q[1 + 2 * i];
            hi = stream_q[2 + 2 * i];
            exp_consumed += 2;
            x = x ^ lo ^ hi;
            if (hi > 1) begin
                exp_err = 1;
                return;
            end
            exp_q.push_back({6'(i), hi[0], lo});
            exp_words++;
        end
`ifdef PROG_LOADER_CKSUM_EN
        exp_consumed++;
        if (stream_q[1 + 2 * n] != x) begin
            exp_err = 1;
            return;
        end
`endif
        exp_done = 1;
    endtask

    task automatic append_cksum(input bit corrupt);
`ifdef PROG_LOADER_CKSUM_EN
        logic [7:0] x = 8'd0;
        foreach (stream_q[i]) x ^= stream_q[i];
        stream_q.push_back(corrupt ? (x ^ 8'h01) : x);
`else
        if (corrupt) stream_q.push_back(8'h00);
`endif
    endtask

    task automatic build_random();
        int kind, len, n, bad;
        stream_q.delete();
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            stream_q.push_back(8'($urandom_range(MAXW + 1, 255)));
            stream_q.push_back(8'($urandom_range(0, 255)));
            return;
        end
        len = $urandom_range(0, MAXW);
        n   = (len == 0) ? MAXW : len;
        bad = (kind == 1) ? int'($urandom_range(0, n - 1)) : -1;
        stream_q.push_back(8'(len));
        for (int i = 0; i < n; i++) begin
            stream_q.push_back(8'($urandom_range(0, 255)));
            stream_q.push_back((i == bad) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1)));
        end
        append_cksum(kind == 2);
    endtask

    // ---------------- driver ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input bit gap);
        int budget = 200;
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check_eq({tag, "_ready_timeout"}, in_ready, 1);
        @(negedge clk);
    endtask

    // gap_mode: 0 back-to-back, 1 valid low every other cycle, 2 random gaps
    task automatic do_load(input string tag, input int gap_mode);
        bit gap;
        run_model();
        done_seen = 0;
        pulse_start();
        check_eq({tag, "_hold_on_start"}, cpu_hold, 1);
        check_eq({tag, "_err_clear"}, error, 0);
        for (int i = 0; i < exp_consumed; i++) begin
            gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 3) == 0);
            send_byte(tag, stream_q[i], gap);
        end
        in_valid = 1'b0;
        if (exp_consumed < stream_q.size()) begin
            in_data  = stream_q[exp_consumed];
            in_valid = 1'b1;
            repeat (3) begin
                check_eq({tag, "_no_ready_after_end"}, in_ready, 0);
                @(negedge clk);
            end
            in_valid = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_eq({tag, "_done_pulses"}, done_seen, exp_done ? 1 : 0);
        check_eq({tag, "_error"}, error, exp_err);
        check_eq({tag, "_cpu_hold"}, cpu_hold, exp_err ? 1 : 0);
        check_eq({tag, "_words"}, words_loaded, exp_words);
        check_eq({tag, "_missing_writes"}, exp_q.size(), 0);
        check_eq({tag, "_ready_idle"}, in_ready, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #1 reset = 1'b0;
        #2;
        check_eq("rst_cpu_hold", cpu_hold, 1);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_imem_we", imem_we, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_words", words_loaded, 0);
        check_eq("rst_addr_data", {imem_addr, imem_wdata}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("idle_in_ready", in_ready, 0);
        check_eq("idle_cpu_hold", cpu_hold, 1);

        stream_q = '{8'h03, 8'hA5, 8'h01, 8'h3C, 8'h00, 8'hFF, 8'h01};
        append_cksum(0);
        do_load("basic", 0);
        check_eq("basic_words_3", words_loaded, 3);

        stream_q = '{8'h03, 8'hA5, 8'h01, 8'h3C, 8'h00, 8'hFF, 8'h01};
        append_cksum(0);
        do_load("gaps", 1);

        stream_q = '{8'h02, 8'h11, 8'h01, 8'h22, 8'h04};
        do_load("bad_hi", 0);
        check_eq("bad_hi_error_set", error, 1);
        pulse_start();
        check_eq("restart_error_clear", error, 0);
        check_eq("restart_hold", cpu_hold, 1);

        stream_q.delete();
        stream_q.push_back(8'h00);
        for (int i = 0; i < MAXW; i++) begin
            stream_q.push_back(8'($urandom_range(0, 255)));
            stream_q.push_back(8'($urandom_range(0, 1)));
        end
        append_cksum(0);
        do_load("len0", 2);
        check_eq("len0_words_64", words_loaded, 64);

        stream_q = '{8'h41, 8'hAA, 8'h55};
        do_load("len_too_big", 0);

        stream_q = '{8'h01, 8'hA5, 8'h01, 8'hA5};
        do_load("cksum_ok", 0);
        stream_q = '{8'h01, 8'hA5, 8'h01, 8'hA4};
        do_load("cksum_bad", 0);

        for (int r = 0; r < 10; r++) begin
            build_random();
            do_load($sformatf("rand%0d", r), int'($urandom_range(0, 2)));
        end

        // asynchronous reset in the middle of a load
        stream_q.delete();
        stream_q.push_back(8'd10);
        for (int i = 0; i < 10; i++) begin
            stream_q.push_back(8'($urandom_range(0, 255)));
            stream_q.push_back(8'($urandom_range(0, 1)));
        end
        run_model();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte("midrst", stream_q[i], 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_eq("midrst_in_ready", in_ready, 0);
        check_eq("midrst_we", imem_we, 0);
        check_eq("midrst_hold", cpu_hold, 1);
        check_eq("midrst_words", words_loaded, 0);
        check_eq("midrst_done_err", {done, error}, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("midrst_idle_ready", in_ready, 0);

        build_random();
        do_load("after_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
